// File: rtl/miter_sweep_ctrl_if.sv
// Connection between the sweep sequencer and the lock-verification miter.
// The sequencer drives the pattern and key, and the miter returns its match flags.
interface miter_sweep_ctrl_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2,
  parameter int KEY_W = 1
);
  logic [IN_W-1:0]  pat_out;
  logic [KEY_W-1:0] key_out;
  logic [OUT_W-1:0] miter_q;
  logic             miter_z;

  modport master (output pat_out, key_out, input miter_q, miter_z);
  modport slave  (input pat_out, key_out, output miter_q, miter_z);
endinterface

// File: rtl/miter_sweep_ctrl.sv
// Exhaustive key validation sequencer: holds a candidate key on the miter, sweeps every
// primary-input pattern, and records the mismatch count, the first failing pattern and pass/fail.
module miter_sweep_ctrl #(
  parameter int IN_W   = 5,
  parameter int OUT_W  = 2,
  parameter int KEY_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic                C,
  input  logic                R,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_W-1:0]    key_in,
  miter_sweep_ctrl_if.master  mif,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [IN_W:0]       mismatch_cnt,
  output logic                fail_seen,
  output logic [IN_W-1:0]     first_fail_pat,
  output logic [OUT_W-1:0]    first_fail_q
);

  localparam int WC_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WC_W-1:0] WC_LOAD  = WC_W'(SETTLE);
  localparam logic [IN_W-1:0] PAT_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_FIN} state_t;

  state_t            state, state_nx;
  logic [WC_W-1:0]   wcnt;
  logic [IN_W-1:0]   pat_r;
  logic [KEY_W-1:0]  key_r;

  assign mif.pat_out = pat_r;
  assign mif.key_out = key_r;

  always_ff @(posedge C or negedge R) begin
    if (!R) state <= S_IDLE;
    else    state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_SETTLE;
      S_SETTLE: begin
        if (abort)              state_nx = S_IDLE;
        else if (wcnt == '0)    state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (abort)                  state_nx = S_IDLE;
        else if (pat_r == PAT_LAST) state_nx = S_FIN;
        else                        state_nx = S_SETTLE;
      end
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_SETTLE) || (state == S_CHECK);
    done = (state == S_FIN);
  end

  // Miter flags are only looked at in CHECK, so settling glitches never count.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      wcnt           <= '0;
      pat_r          <= '0;
      key_r          <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      fail_seen      <= 1'b0;
      first_fail_pat <= '0;
      first_fail_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_r          <= key_in;
            pat_r          <= '0;
            wcnt           <= WC_LOAD;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            fail_seen      <= 1'b0;
            first_fail_pat <= '0;
            first_fail_q   <= '0;
          end
        end
        S_SETTLE: begin
          if (!abort && (wcnt != '0)) wcnt <= wcnt - 1'b1;
        end
        S_CHECK: begin
          if (!abort) begin
            if (!mif.miter_z) begin
              mismatch_cnt <= mismatch_cnt + 1'b1;
              if (!fail_seen) begin
                first_fail_pat <= pat_r;
                first_fail_q   <= mif.miter_q;
                fail_seen      <= 1'b1;
              end
            end
            if (pat_r != PAT_LAST) begin
              pat_r <= pat_r + 1'b1;
              wcnt  <= WC_LOAD;
            end
          end
        end
        S_FIN:   pass <= (mismatch_cnt == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miter_sweep_ctrl.sv
// Bench for miter_sweep_ctrl: three sequencers (SETTLE = 1, 2, 0) driven against small miter models,
// with expected sweep results queued at launch and compared when each done pulse appears.
module tb_miter_sweep_ctrl;
  localparam int IN_W  = 5;
  localparam int OUT_W = 2;
  localparam int KEY_W = 1;

  logic C = 1'b0;
  logic R = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, abort_a = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  int cyc = 0, t0 = 0, mode_a = 0, n_cmp = 0, n_bad = 0;

  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  miter_sweep_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W)) mif_a ();
  miter_sweep_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W)) mif_b ();
  miter_sweep_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W)) mif_c ();

  logic busy_a, done_a, pass_a, fs_a, busy_b, done_b, pass_b, fs_b, busy_c, done_c, pass_c, fs_c;
  logic [IN_W:0]    cnt_a, cnt_b, cnt_c;
  logic [IN_W-1:0]  ffp_a, ffp_b, ffp_c;
  logic [OUT_W-1:0] ffq_a, ffq_b, ffq_c;

  miter_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W), .SETTLE(1)) dut_a (
    .C(C), .R(R), .start(start_a), .abort(abort_a), .key_in(key_in), .mif(mif_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_cnt(cnt_a), .fail_seen(fs_a),
    .first_fail_pat(ffp_a), .first_fail_q(ffq_a));
  miter_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W), .SETTLE(2)) dut_b (
    .C(C), .R(R), .start(start_b), .abort(1'b0), .key_in(key_in), .mif(mif_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(cnt_b), .fail_seen(fs_b),
    .first_fail_pat(ffp_b), .first_fail_q(ffq_b));
  miter_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .KEY_W(KEY_W), .SETTLE(0)) dut_c (
    .C(C), .R(R), .start(start_c), .abort(1'b0), .key_in(key_in), .mif(mif_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_cnt(cnt_c), .fail_seen(fs_c),
    .first_fail_pat(ffp_c), .first_fail_q(ffq_c));

  // Miter A: mode 1 fails pattern 6 (q=01) and pattern 20 (q=10); mode 0 always matches.
  logic z_a;
  logic [OUT_W-1:0] q_a;
  always_comb begin
    z_a = 1'b1;
    q_a = 2'b11;
    if (mode_a == 1 && mif_a.pat_out == 5'd6) begin
      z_a = 1'b0;
      q_a = 2'b01;
    end else if (mode_a == 1 && mif_a.pat_out == 5'd20) begin
      z_a = 1'b0;
      q_a = 2'b10;
    end
  end
  assign mif_a.miter_z = z_a;
  assign mif_a.miter_q = q_a;

  // Miter B: matches only in cycles 4, 8, 12... after start (the CHECK slots for SETTLE=2).
  logic z_b;
  assign z_b = ((cyc - t0) > 0) && (((cyc - t0) % 4) == 0);
  assign mif_b.miter_z = z_b;
  assign mif_b.miter_q = z_b ? 2'b11 : 2'b00;

  // Miter C: fails only the last pattern.
  assign mif_c.miter_z = (mif_c.pat_out != 5'd31);
  assign mif_c.miter_q = (mif_c.pat_out == 5'd31) ? 2'b10 : 2'b11;

  typedef struct packed {
    logic             done;
    logic             busy;
    logic             pass;
    logic [IN_W:0]    cnt;
    logic             fs;
    logic [IN_W-1:0]  ffp;
    logic [OUT_W-1:0] ffq;
    logic [KEY_W-1:0] key;
    logic [IN_W-1:0]  pat;
  } obs_t;

  obs_t obs [3];
  assign obs[0] = {done_a, busy_a, pass_a, cnt_a, fs_a, ffp_a, ffq_a, mif_a.key_out, mif_a.pat_out};
  assign obs[1] = {done_b, busy_b, pass_b, cnt_b, fs_b, ffp_b, ffq_b, mif_b.key_out, mif_b.pat_out};
  assign obs[2] = {done_c, busy_c, pass_c, cnt_c, fs_c, ffp_c, ffq_c, mif_c.key_out, mif_c.pat_out};

  typedef struct {
    int               id;
    int               exp_cyc;
    logic [IN_W:0]    cnt;
    logic             fs;
    logic [IN_W-1:0]  ffp;
    logic [OUT_W-1:0] ffq;
    logic [KEY_W-1:0] key;
    logic             pass;
  } exp_t;

  exp_t sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mon_e;
  int   mon_id;
  always @(negedge C) begin
    if (obs[0].done || obs[1].done || obs[2].done) begin
      mon_id = obs[0].done ? 0 : (obs[1].done ? 1 : 2);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: instance %0d pulsed done with no sweep pending (cycle %0d)", mon_id, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_instance", mon_id, mon_e.id);
        chk("done_cycle", cyc, mon_e.exp_cyc);
        chk("mismatch_cnt", obs[mon_id].cnt, mon_e.cnt);
        chk("fail_seen", obs[mon_id].fs, mon_e.fs);
        chk("first_fail_pat", obs[mon_id].ffp, mon_e.ffp);
        chk("first_fail_q", obs[mon_id].ffq, mon_e.ffq);
        chk("key_out", obs[mon_id].key, mon_e.key);
        @(negedge C);
        chk("pass", obs[mon_id].pass, mon_e.pass);
        chk("done_one_cycle", obs[mon_id].done, 1'b0);
      end
    end
  end

  task automatic launch(input int id, input logic k, input int lat, input logic push,
                        input logic [IN_W:0] cnt, input logic fs, input logic [IN_W-1:0] ffp,
                        input logic [OUT_W-1:0] ffq, input logic pas);
    exp_t e;
    @(negedge C);
    key_in = k;
    t0 = cyc;
    if (push) begin
      e.id = id; e.exp_cyc = cyc + lat; e.cnt = cnt; e.fs = fs;
      e.ffp = ffp; e.ffq = ffq; e.key = k; e.pass = pas;
      sb_q.push_back(e);
    end
    case (id)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge C);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_sb(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge C);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout: no done within %0d cycles, %0d results pending", limit, sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(negedge C);
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - t0) < n) @(negedge C);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge C);
    chk("reset_a", obs[0], 0);
    chk("reset_b", obs[1], 0);
    chk("reset_c", obs[2], 0);
    R = 1'b1;
    @(negedge C);

    // All patterns match, key 1.
    mode_a = 0;
    launch(0, 1'b1, 97, 1'b1, 0, 1'b0, 0, 2'b00, 1'b1);
    wait_sb(200);

    // Mismatches at patterns 6 and 20.
    mode_a = 1;
    launch(0, 1'b0, 97, 1'b1, 2, 1'b1, 5'd6, 2'b01, 1'b0);
    wait_sb(200);

    // Start re-pulsed mid-sweep with a different key is ignored.
    mode_a = 0;
    launch(0, 1'b0, 97, 1'b1, 0, 1'b0, 0, 2'b00, 1'b1);
    wait_rel(30);
    start_a = 1'b1;
    key_in  = 1'b1;
    @(negedge C);
    start_a = 1'b0;
    key_in  = 1'b0;
    chk("restart_key_hold", obs[0].key, 1'b0);
    chk("restart_busy", obs[0].busy, 1'b1);
    wait_sb(200);

    // Abort during a sweep that has already recorded the pattern-6 mismatch.
    mode_a = 1;
    launch(0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0);
    wait_rel(40);
    abort_a = 1'b1;
    @(negedge C);
    abort_a = 1'b0;
    chk("abort_busy", obs[0].busy, 1'b0);
    @(negedge C);
    chk("abort_cnt", obs[0].cnt, 1);
    chk("abort_fail_seen", obs[0].fs, 1'b1);
    chk("abort_ffp", obs[0].ffp, 5'd6);
    chk("abort_ffq", obs[0].ffq, 2'b01);
    chk("abort_pass", obs[0].pass, 1'b0);
    chk("abort_key", obs[0].key, 1'b1);
    repeat (80) @(negedge C);

    // Asynchronous reset mid-sweep, then a fresh sweep.
    mode_a = 0;
    launch(0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 2'b00, 1'b0);
    wait_rel(50);
    chk("pre_reset_busy", obs[0].busy, 1'b1);
    R = 1'b0;
    #1;
    chk("async_reset", obs[0], 0);
    @(negedge C);
    R = 1'b1;
    @(negedge C);
    mode_a = 1;
    launch(0, 1'b1, 97, 1'b1, 2, 1'b1, 5'd6, 2'b01, 1'b0);
    wait_sb(200);

    // SETTLE=2 with the miter mismatching in every settle cycle.
    launch(1, 1'b1, 129, 1'b1, 0, 1'b0, 0, 2'b00, 1'b1);
    wait_sb(250);

    // SETTLE=0 with only the last pattern failing.
    launch(2, 1'b1, 65, 1'b1, 1, 1'b1, 5'd31, 2'b10, 1'b0);
    wait_sb(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
